// File: rtl/instr_fetch_stage_if.sv
// Fetch-to-execute bus: instruction register fields, valid/ready handshake and PC redirect.
// The fetch stage drives the master side; the execute stage uses the slave side.
interface instr_fetch_stage_if #(
  parameter int unsigned ADDR_W = 8
);
  localparam int unsigned CMD_W  = 4;
  localparam int unsigned QUAL_W = 3;
  localparam int unsigned TYPE_W = 2;
  localparam int unsigned VAL_W  = 8;

  logic                ex_valid;
  logic                ex_ready;
  logic                br_valid;
  logic [ADDR_W-1:0]   br_target;
  logic [CMD_W-1:0]    ir_cmd;
  logic [QUAL_W-1:0]   ir_qual;
  logic [TYPE_W-1:0]   ir_s1_type;
  logic [VAL_W-1:0]    ir_s1_val;
  logic [TYPE_W-1:0]   ir_s2_type;
  logic [VAL_W-1:0]    ir_s2_val;
  logic [VAL_W-1:0]    ir_target;
  logic [ADDR_W-1:0]   ir_pc;

  modport master (
    output ex_valid, ir_cmd, ir_qual, ir_s1_type, ir_s1_val,
           ir_s2_type, ir_s2_val, ir_target, ir_pc,
    input  ex_ready, br_valid, br_target
  );

  modport slave (
    input  ex_valid, ir_cmd, ir_qual, ir_s1_type, ir_s1_val,
           ir_s2_type, ir_s2_val, ir_target, ir_pc,
    output ex_ready, br_valid, br_target
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Program sequencer + instruction register for the calculator CPU (pc -> IR, two registers deep).
// Optional NOP_SKIP_EN: all-zero ROM words advance the pc but are never presented to execute.
module instr_fetch_stage #(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       INSTR_W   = 35,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [INSTR_W-1:0]  rom_data,
  input  logic                halt,
  output logic [CNT_W-1:0]    retired,
  instr_fetch_stage_if.master ex
);

  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               valid;
  logic               load;
  logic               consume;
  logic               skip;

  always_comb begin
    load    = 1'b0;
    consume = 1'b0;
    skip    = 1'b0;
    load    = !halt && !ex.br_valid && (!valid || ex.ex_ready);
    consume = valid && ex.ex_ready && !ex.br_valid;
`ifdef NOP_SKIP_EN
    skip    = (rom_data == '0);
`endif
  end

  // Redirect beats load, stall and halt; a halted stage can still be drained once.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_VEC;
      ir      <= '0;
      ir_pc   <= '0;
      valid   <= 1'b0;
      retired <= '0;
    end else begin
      if (consume && (retired != '1)) begin
        retired <= retired + CNT_W'(1);
      end
      if (ex.br_valid) begin
        pc    <= ex.br_target;
        valid <= 1'b0;
      end else if (load) begin
        ir    <= rom_data;
        ir_pc <= pc;
        pc    <= pc + ADDR_W'(1);
        valid <= !skip;
      end else if (consume) begin
        valid <= 1'b0;
      end
    end
  end

  assign rom_addr      = pc;
  assign ex.ex_valid   = valid;
  assign ex.ir_pc      = ir_pc;
  assign ex.ir_cmd     = ir[34:31];
  assign ex.ir_qual    = ir[30:28];
  assign ex.ir_s1_type = ir[27:26];
  assign ex.ir_s1_val  = ir[25:18];
  assign ex.ir_s2_type = ir[17:16];
  assign ex.ir_s2_val  = ir[15:8];
  assign ex.ir_target  = ir[7:0];

endmodule
